// File: rtl/word_gen_conf_pkg.sv
// Shared definitions for the word generator range configuration writer:
// FSM encoding, default terminator byte and small index/size helpers.
package word_gen_conf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RD_NRANGES = 3'd1,
        ST_RD_NUM     = 3'd2,
        ST_RD_CHARS   = 3'd3,
        ST_RD_TERM    = 3'd4,
        ST_CLEAR      = 3'd5,
        ST_FIN        = 3'd6,
        ST_ERR        = 3'd7
    } conf_state_t;

    // End-of-stream marker that must follow the last range definition.
    localparam logic [7:0] TERM_BYTE_DEF = 8'hBB;

    // Widest one-hot vector the helper can build; RANGES_MAX must not exceed it.
    localparam int unsigned ONEHOT_W   = 32'd32;
    localparam logic [7:0]  ONEHOT_W_B = 8'd32;

    // 7-bit chars allow every code 0..127 in one range; 8-bit chars are capped
    // by the 8-bit N field at 255.
    function automatic int unsigned chars_number_max(input int unsigned char_bits);
        int unsigned n;
        if (char_bits == 32'd7) begin
            n = 32'd128;
        end else begin
            n = 32'd255;
        end
        return n;
    endfunction

    // One-hot decode of a range index; out-of-range indices give all zeros.
    function automatic logic [ONEHOT_W-1:0] onehot(input logic [7:0] idx);
        logic [ONEHOT_W-1:0] v;
        v = '0;
        if (idx < ONEHOT_W_B) begin
            v[idx[4:0]] = 1'b1;
        end else begin
            v = '0;
        end
        return v;
    endfunction

endpackage

// File: rtl/word_gen_range_conf.sv
// Configuration writer for the per-position character ranges of the word
// generator. Parses R, then (N, N chars) per range, then the terminator, and
// turns each byte into a registered write strobe. Positions beyond R are
// explicitly loaded as empty so no range from an earlier pass survives.
module word_gen_range_conf
    import word_gen_conf_pkg::*;
#(
    parameter int unsigned CHAR_BITS        = 32'd7,
    parameter int unsigned CHARS_NUMBER_MAX = chars_number_max(CHAR_BITS),
    parameter int unsigned RANGES_MAX       = 32'd16,
    parameter logic [7:0]  TERM_BYTE        = TERM_BYTE_DEF
)(
    input  logic                  CLK,
    input  logic                  rst_n,
    input  logic [7:0]            din,
    input  logic                  empty,
    output logic                  rd_en,
    input  logic                  start,
    output logic [RANGES_MAX-1:0] range_sel,
    output logic                  conf_en_num_chars,
    output logic                  num_chars_eq0,
    output logic                  num_chars_lt2,
    output logic                  conf_en_chars,
    output logic [CHAR_BITS-1:0]  conf_char_addr,
    output logic [CHAR_BITS-1:0]  conf_dout,
    output logic                  pre_end_char,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    // Index counter must be able to hold RANGES_MAX itself (latched R).
    localparam int unsigned    IW        = $clog2(RANGES_MAX + 32'd1);
    localparam logic [IW-1:0]  RMAX_I    = IW'(RANGES_MAX);
    localparam logic [IW-1:0]  RLAST_I   = IW'(RANGES_MAX - 32'd1);
    localparam logic [IW-1:0]  ONE_I     = IW'(32'd1);
    localparam logic [7:0]     RMAX_B    = 8'(RANGES_MAX);
    localparam logic [8:0]     NMAX9     = 9'(CHARS_NUMBER_MAX);
    localparam bit             CHECK_MSB = (CHAR_BITS == 32'd7);

    conf_state_t           state_r, state_s;
    logic [IW-1:0]         nranges_r, nranges_s;
    logic [IW-1:0]         idx_r, idx_s;
    logic [7:0]            nchars_r, nchars_s;
    logic [7:0]            char_cnt_r, char_cnt_s;

    logic [RANGES_MAX-1:0] range_sel_r, range_sel_s;
    logic                  en_num_r, en_num_s;
    logic                  eq0_r, eq0_s;
    logic                  lt2_r, lt2_s;
    logic                  en_chars_r, en_chars_s;
    logic [CHAR_BITS-1:0]  addr_r, addr_s;
    logic [CHAR_BITS-1:0]  dout_r, dout_s;
    logic                  pre_r, pre_s;
    logic                  busy_r, busy_s;
    logic                  done_r, done_s;
    logic                  error_r, error_s;

    logic                  rd_s;
    logic [RANGES_MAX-1:0] cur_sel_s;
    logic                  last_range_s;
    logic                  last_char_s;
    logic                  pre_char_s;

    // FIFO read strobe: only the parsing states pull bytes, and only when one is available.
    always_comb begin
        rd_s = 1'b0;
        case (state_r)
            ST_RD_NRANGES, ST_RD_NUM, ST_RD_CHARS, ST_RD_TERM: rd_s = ~empty;
            default:                                           rd_s = 1'b0;
        endcase
    end

    assign rd_en = rd_s;

    // Position decode and end-of-range / end-of-stream conditions; 9-bit sums keep N-2 from underflowing.
    always_comb begin
        cur_sel_s    = RANGES_MAX'(onehot(8'(idx_r)));
        last_range_s = ((idx_r + ONE_I) == nranges_r);
        last_char_s  = (({1'b0, char_cnt_r} + 9'd1) == {1'b0, nchars_r});
        pre_char_s   = (({1'b0, char_cnt_r} + 9'd2) == {1'b0, nchars_r});
    end

    // Next-state and next-output logic; every strobe is produced here and registered below.
    always_comb begin
        state_s     = state_r;
        nranges_s   = nranges_r;
        idx_s       = idx_r;
        nchars_s    = nchars_r;
        char_cnt_s  = char_cnt_r;
        range_sel_s = '0;
        en_num_s    = 1'b0;
        eq0_s       = 1'b0;
        lt2_s       = 1'b0;
        en_chars_s  = 1'b0;
        addr_s      = '0;
        dout_s      = '0;
        pre_s       = 1'b0;
        busy_s      = busy_r;
        done_s      = 1'b0;
        error_s     = error_r;

        case (state_r)
            ST_IDLE, ST_ERR: begin
                if (start) begin
                    state_s = ST_RD_NRANGES;
                    error_s = 1'b0;
                    busy_s  = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end

            ST_RD_NRANGES: begin
                if (!rd_s) begin
                    state_s = state_r;
                end else if ((din == 8'd0) || (din > RMAX_B)) begin
                    state_s = ST_ERR;
                    error_s = 1'b1;
                    busy_s  = 1'b0;
                end else begin
                    nranges_s = din[IW-1:0];
                    idx_s     = '0;
                    state_s   = ST_RD_NUM;
                end
            end

            ST_RD_NUM: begin
                if (!rd_s) begin
                    state_s = state_r;
                end else if ({1'b0, din} > NMAX9) begin
                    state_s = ST_ERR;
                    error_s = 1'b1;
                    busy_s  = 1'b0;
                end else begin
                    en_num_s    = 1'b1;
                    range_sel_s = cur_sel_s;
                    eq0_s       = (din == 8'd0);
                    lt2_s       = (din < 8'd2);
                    nchars_s    = din;
                    if (din != 8'd0) begin
                        char_cnt_s = 8'd0;
                        state_s    = ST_RD_CHARS;
                    end else if (last_range_s) begin
                        state_s = ST_RD_TERM;
                    end else begin
                        idx_s   = idx_r + ONE_I;
                        state_s = ST_RD_NUM;
                    end
                end
            end

            ST_RD_CHARS: begin
                if (!rd_s) begin
                    state_s = state_r;
                end else if (CHECK_MSB && din[7]) begin
                    state_s = ST_ERR;
                    error_s = 1'b1;
                    busy_s  = 1'b0;
                end else begin
                    en_chars_s  = 1'b1;
                    range_sel_s = cur_sel_s;
                    addr_s      = char_cnt_r[CHAR_BITS-1:0];
                    dout_s      = din[CHAR_BITS-1:0];
                    pre_s       = pre_char_s;
                    if (!last_char_s) begin
                        char_cnt_s = char_cnt_r + 8'd1;
                    end else if (last_range_s) begin
                        state_s = ST_RD_TERM;
                    end else begin
                        idx_s   = idx_r + ONE_I;
                        state_s = ST_RD_NUM;
                    end
                end
            end

            ST_RD_TERM: begin
                if (!rd_s) begin
                    state_s = state_r;
                end else if (din != TERM_BYTE) begin
                    state_s = ST_ERR;
                    error_s = 1'b1;
                    busy_s  = 1'b0;
                end else if (nranges_r == RMAX_I) begin
                    state_s = ST_FIN;
                end else begin
                    idx_s   = nranges_r;
                    state_s = ST_CLEAR;
                end
            end

            ST_CLEAR: begin
                en_num_s    = 1'b1;
                eq0_s       = 1'b1;
                lt2_s       = 1'b1;
                range_sel_s = cur_sel_s;
                if (idx_r == RLAST_I) begin
                    state_s = ST_FIN;
                end else begin
                    idx_s = idx_r + ONE_I;
                end
            end

            ST_FIN: begin
                done_s  = 1'b1;
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end

            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // Parser state and counters; async reset abandons any pass in flight.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            nranges_r  <= '0;
            idx_r      <= '0;
            nchars_r   <= 8'd0;
            char_cnt_r <= 8'd0;
        end else begin
            state_r    <= state_s;
            nranges_r  <= nranges_s;
            idx_r      <= idx_s;
            nchars_r   <= nchars_s;
            char_cnt_r <= char_cnt_s;
        end
    end

    // Output registers: strobes land one cycle after the edge that consumed their byte.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            range_sel_r <= '0;
            en_num_r    <= 1'b0;
            eq0_r       <= 1'b0;
            lt2_r       <= 1'b0;
            en_chars_r  <= 1'b0;
            addr_r      <= '0;
            dout_r      <= '0;
            pre_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            range_sel_r <= range_sel_s;
            en_num_r    <= en_num_s;
            eq0_r       <= eq0_s;
            lt2_r       <= lt2_s;
            en_chars_r  <= en_chars_s;
            addr_r      <= addr_s;
            dout_r      <= dout_s;
            pre_r       <= pre_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            error_r     <= error_s;
        end
    end

    assign range_sel         = range_sel_r;
    assign conf_en_num_chars = en_num_r;
    assign num_chars_eq0     = eq0_r;
    assign num_chars_lt2     = lt2_r;
    assign conf_en_chars     = en_chars_r;
    assign conf_char_addr    = addr_r;
    assign conf_dout         = dout_r;
    assign pre_end_char      = pre_r;
    assign busy              = busy_r;
    assign done              = done_r;
    assign error             = error_r;

endmodule

// File: tb/tb_word_gen_range_conf.sv
// Bench for word_gen_range_conf (CHAR_BITS=7, RANGES_MAX=4). A byte-queue FIFO
// model feeds the DUT; each test pushes its stream and the hand-derived strobe
// sequence; a monitor pops and compares every strobe the DUT presents.
module tb_word_gen_range_conf;

    localparam int RM = 4;

    logic          CLK = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    din = 8'h00;
    logic          empty = 1'b1;
    logic          rd_en;
    logic          start = 1'b0;
    logic [RM-1:0] range_sel;
    logic          conf_en_num_chars, num_chars_eq0, num_chars_lt2;
    logic          conf_en_chars;
    logic [6:0]    conf_char_addr, conf_dout;
    logic          pre_end_char, busy, done, error;

    typedef logic [22:0] ev_t;
    ev_t        exp_q[$];
    logic [7:0] fifo[$];
    bit         stall_mode = 1'b0;
    bit         stall = 1'b0;
    int         n_cmp = 0;
    int         n_bad = 0;

    word_gen_range_conf #(.CHAR_BITS(7), .RANGES_MAX(RM)) dut (
        .CLK(CLK), .rst_n(rst_n), .din(din), .empty(empty), .rd_en(rd_en),
        .start(start), .range_sel(range_sel),
        .conf_en_num_chars(conf_en_num_chars), .num_chars_eq0(num_chars_eq0),
        .num_chars_lt2(num_chars_lt2), .conf_en_chars(conf_en_chars),
        .conf_char_addr(conf_char_addr), .conf_dout(conf_dout),
        .pre_end_char(pre_end_char), .busy(busy), .done(done), .error(error)
    );

    // Free-running clock, period 10.
    always #5 CLK = ~CLK;

    function automatic ev_t ev_num(input logic [3:0] sel, input logic eq0, input logic lt2);
        return {2'd1, sel, eq0, lt2, 1'b0, 7'd0, 7'd0};
    endfunction

    function automatic ev_t ev_chr(input logic [3:0] sel, input logic [6:0] addr,
                                   input logic [6:0] d, input logic pre);
        return {2'd2, sel, 2'b00, pre, addr, d};
    endfunction

    function automatic ev_t ev_done();
        return {2'd3, 21'd0};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // FIFO model: pop the byte the DUT read at this edge, then present the next one.
    initial begin
        bit rd_seen;
        forever begin
            @(negedge CLK);
            rd_seen = rd_en;
            @(posedge CLK);
            if (rd_seen && fifo.size() > 0) void'(fifo.pop_front());
            #1;
            if (stall_mode) stall = ~stall; else stall = 1'b0;
            empty = stall | (fifo.size() == 0);
            din   = (fifo.size() > 0) ? fifo[0] : 8'h00;
        end
    end

    // Monitor: every presented strobe or done must match the head of the scoreboard.
    initial begin
        bit  prev_rd;
        ev_t got;
        ev_t exp;
        prev_rd = 1'b0;
        forever begin
            @(negedge CLK);
            if (rst_n && (conf_en_num_chars || conf_en_chars || done)) begin
                if (conf_en_num_chars && conf_en_chars) got = '0;
                else if (conf_en_num_chars) got = ev_num(range_sel, num_chars_eq0, num_chars_lt2);
                else if (conf_en_chars) got = ev_chr(range_sel, conf_char_addr, conf_dout, pre_end_char);
                else got = ev_done();
                if (conf_en_chars) check("char_after_rd_en", prev_rd, 1);
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", got, 0);
                end else begin
                    exp = exp_q.pop_front();
                    check("strobe", got, exp);
                end
            end
            prev_rd = rd_en;
        end
    end

    task automatic pulse_start();
        @(posedge CLK); #1 start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
        @(negedge CLK);
        check("started_busy_err", {busy, error}, 2'b10);
    endtask

    // Run one pass to completion and check its end state.
    task automatic run_pass(input string name, input int budget, input logic exp_err,
                            input int exp_left, input bit poke);
        int i;
        pulse_start();
        for (i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (poke && i == 3) start = 1'b1;
            if (poke && i == 4) start = 1'b0;
            if (!busy) break;
        end
        start = 1'b0;
        check({name, "_busy_end"}, busy, 0);
        repeat (3) @(negedge CLK);
        check({name, "_error"}, error, exp_err);
        check({name, "_done_low"}, done, 0);
        check({name, "_pending"}, exp_q.size(), 0);
        check({name, "_fifo_left"}, fifo.size(), exp_left);
        check({name, "_rd_en_idle"}, rd_en, 0);
        fifo.delete();
        exp_q.delete();
    endtask

    task automatic load_t1();
        logic [7:0] s[8];
        s = '{8'h02, 8'h03, 8'h61, 8'h62, 8'h63, 8'h01, 8'h7A, 8'hBB};
        foreach (s[i]) fifo.push_back(s[i]);
        exp_q.push_back(ev_num(4'b0001, 1'b0, 1'b0));
        exp_q.push_back(ev_chr(4'b0001, 7'd0, 7'h61, 1'b0));
        exp_q.push_back(ev_chr(4'b0001, 7'd1, 7'h62, 1'b1));
        exp_q.push_back(ev_chr(4'b0001, 7'd2, 7'h63, 1'b0));
        exp_q.push_back(ev_num(4'b0010, 1'b0, 1'b1));
        exp_q.push_back(ev_chr(4'b0010, 7'd0, 7'h7A, 1'b0));
        exp_q.push_back(ev_num(4'b0100, 1'b1, 1'b1));
        exp_q.push_back(ev_num(4'b1000, 1'b1, 1'b1));
        exp_q.push_back(ev_done());
    endtask

    task automatic load_t2();
        fifo.push_back(8'h01); fifo.push_back(8'h00); fifo.push_back(8'hBB);
        exp_q.push_back(ev_num(4'b0001, 1'b1, 1'b1));
        exp_q.push_back(ev_num(4'b0010, 1'b1, 1'b1));
        exp_q.push_back(ev_num(4'b0100, 1'b1, 1'b1));
        exp_q.push_back(ev_num(4'b1000, 1'b1, 1'b1));
        exp_q.push_back(ev_done());
    endtask

    // Main stimulus sequence.
    initial begin
        repeat (3) @(negedge CLK);
        check("reset_outputs",
              {range_sel, conf_en_num_chars, num_chars_eq0, num_chars_lt2, conf_en_chars,
               conf_char_addr, conf_dout, pre_end_char, busy, done, error, rd_en}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge CLK);

        // 1: two ranges, clears for positions 2 and 3
        load_t1();
        run_pass("t1", 200, 1'b0, 0, 1'b0);

        // 2: single empty range
        load_t2();
        run_pass("t2", 200, 1'b0, 0, 1'b0);

        // 3: bad terminator; trailing byte must stay in the FIFO
        fifo.push_back(8'h01); fifo.push_back(8'h01); fifo.push_back(8'h78);
        fifo.push_back(8'hCC); fifo.push_back(8'h55);
        exp_q.push_back(ev_num(4'b0001, 1'b0, 1'b1));
        exp_q.push_back(ev_chr(4'b0001, 7'd0, 7'h78, 1'b0));
        run_pass("t3", 200, 1'b1, 1, 1'b0);

        // 4: protocol errors, none of which strobes for the offending byte
        fifo.push_back(8'h00);
        run_pass("t4_r0", 200, 1'b1, 0, 1'b0);
        fifo.push_back(8'h05);
        run_pass("t4_r5", 200, 1'b1, 0, 1'b0);
        fifo.push_back(8'h01); fifo.push_back(8'h81);
        run_pass("t4_n129", 200, 1'b1, 0, 1'b0);
        fifo.push_back(8'h01); fifo.push_back(8'h02); fifo.push_back(8'h80); fifo.push_back(8'h41);
        exp_q.push_back(ev_num(4'b0001, 1'b0, 1'b0));
        run_pass("t4_msb", 200, 1'b1, 1, 1'b0);

        // 5: test-1 stream with the FIFO stalling every other cycle, plus a start while busy
        stall_mode = 1'b1;
        load_t1();
        run_pass("t5", 400, 1'b0, 0, 1'b1);
        stall_mode = 1'b0;

        // 6: full load, every position holds 128 chars, no clears
        fifo.push_back(8'h04);
        for (int r = 0; r < RM; r++) begin
            logic [3:0] sel;
            sel = 4'b0001 << r;
            fifo.push_back(8'd128);
            exp_q.push_back(ev_num(sel, 1'b0, 1'b0));
            for (int c = 0; c < 128; c++) begin
                fifo.push_back(8'(c));
                exp_q.push_back(ev_chr(sel, 7'(c), 7'(c), (c == 126)));
            end
        end
        fifo.push_back(8'hBB);
        exp_q.push_back(ev_done());
        run_pass("t6_full", 2000, 1'b0, 0, 1'b0);

        // 6b: async reset in the middle of the char phase
        fifo.push_back(8'h01); fifo.push_back(8'h05);
        for (int c = 0; c < 5; c++) fifo.push_back(8'h41 + 8'(c));
        fifo.push_back(8'hBB);
        exp_q.push_back(ev_num(4'b0001, 1'b0, 1'b0));
        for (int c = 0; c < 5; c++) exp_q.push_back(ev_chr(4'b0001, 7'(c), 7'h41 + 7'(c), (c == 3)));
        pulse_start();
        begin
            int k;
            for (k = 0; k < 50; k++) begin
                if (conf_en_chars) break;
                @(negedge CLK);
            end
            check("t6_reached_chars", conf_en_chars, 1);
        end
        #2 rst_n = 1'b0;
        #1;
        check("t6_reset_outputs",
              {range_sel, conf_en_num_chars, num_chars_eq0, num_chars_lt2, conf_en_chars,
               conf_char_addr, conf_dout, pre_end_char, busy, done, error, rd_en}, 0);
        exp_q.delete();
        fifo.delete();
        repeat (2) @(negedge CLK);
        rst_n = 1'b1;
        repeat (5) @(negedge CLK);
        check("t6_quiet_after_reset", {conf_en_num_chars, conf_en_chars, busy, done}, 0);

        // recovery after reset
        load_t2();
        run_pass("t6_recover", 200, 1'b0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
